// File: rtl/frontend_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frontend_sched_pkg
// Purpose  : Shared types for the frontend command scheduler: opcode and
//            intake-state encodings plus default-configuration entry layouts.
// Revision : 1.0 - initial release
// ============================================================================
package frontend_sched_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } intake_state_e;

    // Default configuration widths; the queue entry layouts below match the
    // flat packing the scheduler uses (address in the MSBs).
    localparam int ADDR_W_DEF    = 32;
    localparam int ID_W_DEF      = 4;
    localparam int DATA_W_DEF    = 64;
    localparam int BURST_LEN_DEF = 4;
    localparam int LINE_W_DEF    = DATA_W_DEF * BURST_LEN_DEF;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [ID_W_DEF-1:0]   id;
    } rq_entry_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [ID_W_DEF-1:0]   id;
        logic [LINE_W_DEF-1:0] line;
    } wq_entry_t;

endpackage
`default_nettype wire

// File: rtl/frontend_cmd_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sched_fifo
// Purpose  : Synchronous FIFO with exact occupancy count, plus a per-slot
//            valid vector and the key field (entry MSBs) of every slot so the
//            owner can do associative address compares.
// Revision : 1.0 - initial release
// ============================================================================
module sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int KEY_W = WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [DEPTH-1:0]         o_valid,
    output logic [DEPTH*KEY_W-1:0]   o_keys
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the valid vector masks stale slots.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] w_off;
        assign w_off = PTR_W'(i) - r_rd_ptr;
        assign o_valid[i] = ({1'b0, w_off} < r_count);
        assign o_keys[i*KEY_W +: KEY_W] = r_mem[i][WIDTH-1 -: KEY_W];
    end

endmodule
`default_nettype wire

// File: rtl/frontend_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frontend_cmd_scheduler
// Purpose  : Buffers host reads and burst writes in separate queues and issues
//            them one at a time to the DRAM backend. Reads bypass older writes
//            unless a same-address hazard exists; a write watermark drains.
// Revision : 1.0 - initial release
// ============================================================================
module frontend_cmd_scheduler
    import frontend_sched_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int RQ_DEPTH  = 8,
    parameter int WQ_DEPTH  = 8,
    parameter int WQ_HI     = 6,
    parameter int WQ_LO     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_cmd_valid,
    output logic                        i_cmd_ready,
    input  logic                        i_cmd_op,
    input  logic [ADDR_W-1:0]           i_cmd_addr,
    input  logic [ID_W-1:0]             i_cmd_id,
    input  logic                        i_wdata_valid,
    output logic                        i_wdata_ready,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic                        i_wlast,
    output logic                        o_cmd_valid,
    input  logic                        o_cmd_ready,
    output logic                        o_cmd_op,
    output logic [ADDR_W-1:0]           o_cmd_addr,
    output logic [ID_W-1:0]             o_cmd_id,
    output logic [DATA_W*BURST_LEN-1:0] o_cmd_wline,
    output logic [$clog2(RQ_DEPTH):0]   o_rq_count,
    output logic [$clog2(WQ_DEPTH):0]   o_wq_count,
    output logic                        o_drain,
    output logic                        o_burst_err
);

    localparam int LINE_W = DATA_W * BURST_LEN;
    localparam int RQ_W   = ADDR_W + ID_W;
    localparam int WQ_W   = RQ_W + LINE_W;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int WQ_CW  = $clog2(WQ_DEPTH) + 1;

    intake_state_e          r_state, w_state_next;
    logic                   r_ready_en;
    logic [ADDR_W-1:0]      r_col_addr;
    logic [ID_W-1:0]        r_col_id;
    logic [LINE_W-1:0]      r_line;
    logic [BEAT_W-1:0]      r_beat_cnt;
    logic                   r_burst_err;
    logic                   r_drain;
    logic                   r_out_valid;
    logic                   r_out_op;
    logic [ADDR_W-1:0]      r_out_addr;
    logic [ID_W-1:0]        r_out_id;
    logic [LINE_W-1:0]      r_out_line;

    logic                   w_cmd_ready, w_wdata_ready;
    logic                   w_rd_fire, w_wr_fire, w_beat_fire, w_beat_keep;
    logic [LINE_W-1:0]      w_push_line;
    logic                   w_wq_push, w_rq_pop, w_wq_pop;
    logic [RQ_W-1:0]        w_rq_head;
    logic [WQ_W-1:0]        w_wq_head;
    logic                   w_rq_full, w_rq_empty, w_wq_full, w_wq_empty;
    logic [RQ_DEPTH-1:0]    w_rq_valid, w_war_vec;
    logic [WQ_DEPTH-1:0]    w_wq_valid, w_raw_vec;
    logic [RQ_DEPTH*ADDR_W-1:0] w_rq_keys;
    logic [WQ_DEPTH*ADDR_W-1:0] w_wq_keys;
    logic [ADDR_W-1:0]      w_rq_head_addr;
    logic                   w_war_hit, w_raw, w_load, w_sel_w, w_sel_r;
    logic [WQ_CW-1:0]       w_wq_count_next;

    assign i_cmd_ready   = w_cmd_ready;
    assign i_wdata_ready = w_wdata_ready;
    assign w_rd_fire     = i_cmd_valid & w_cmd_ready & (i_cmd_op == OP_READ);
    assign w_wr_fire     = i_cmd_valid & w_cmd_ready & (i_cmd_op == OP_WRITE);
    assign w_beat_fire   = i_wdata_valid & w_wdata_ready;
    assign w_beat_keep   = (r_beat_cnt < BEAT_W'(BURST_LEN));
    assign w_wq_push     = w_beat_fire & i_wlast;

    // Intake state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Intake next-state and handshake readies; writes are held off while a
    // read to the same address is still queued so the read sees old data.
    always_comb begin
        w_state_next  = r_state;
        w_cmd_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cmd_op == OP_WRITE) w_cmd_ready = r_ready_en & ~w_wq_full & ~w_war_hit;
                else                      w_cmd_ready = r_ready_en & ~w_rq_full;
                if (i_cmd_valid && w_cmd_ready && i_cmd_op == OP_WRITE) w_state_next = COLLECT;
            end
            COLLECT: begin
                w_wdata_ready = 1'b1;
                if (i_wdata_valid && i_wlast) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line as it will be pushed: collected beats plus the current beat.
    always_comb begin
        w_push_line = r_line;
        if (w_beat_keep) w_push_line[r_beat_cnt*DATA_W +: DATA_W] = i_wdata;
    end

    // Write line collection, ready enable and sticky overlong-burst flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready_en  <= 1'b0;
            r_col_addr  <= '0;
            r_col_id    <= '0;
            r_line      <= '0;
            r_beat_cnt  <= '0;
            r_burst_err <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_wr_fire) begin
                r_col_addr <= i_cmd_addr;
                r_col_id   <= i_cmd_id;
                r_line     <= '0;
                r_beat_cnt <= '0;
            end
            if (w_beat_fire) begin
                r_line <= w_push_line;
                if (w_beat_keep) r_beat_cnt  <= r_beat_cnt + 1'b1;
                else             r_burst_err <= 1'b1;
            end
        end
    end

    sched_fifo #(.WIDTH(RQ_W), .DEPTH(RQ_DEPTH), .KEY_W(ADDR_W)) u_rq (
        .clk(clk), .rst_n(rst_n),
        .i_push(w_rd_fire), .i_data({i_cmd_addr, i_cmd_id}), .i_pop(w_rq_pop),
        .o_head(w_rq_head), .o_full(w_rq_full), .o_empty(w_rq_empty),
        .o_count(o_rq_count), .o_valid(w_rq_valid), .o_keys(w_rq_keys)
    );

    sched_fifo #(.WIDTH(WQ_W), .DEPTH(WQ_DEPTH), .KEY_W(ADDR_W)) u_wq (
        .clk(clk), .rst_n(rst_n),
        .i_push(w_wq_push), .i_data({r_col_addr, r_col_id, w_push_line}), .i_pop(w_wq_pop),
        .o_head(w_wq_head), .o_full(w_wq_full), .o_empty(w_wq_empty),
        .o_count(o_wq_count), .o_valid(w_wq_valid), .o_keys(w_wq_keys)
    );

    assign w_rq_head_addr = w_rq_head[RQ_W-1 -: ADDR_W];

    for (genvar i = 0; i < RQ_DEPTH; i++) begin : g_war
        assign w_war_vec[i] = w_rq_valid[i] & (w_rq_keys[i*ADDR_W +: ADDR_W] == i_cmd_addr);
    end

    for (genvar i = 0; i < WQ_DEPTH; i++) begin : g_raw
        assign w_raw_vec[i] = w_wq_valid[i] & (w_wq_keys[i*ADDR_W +: ADDR_W] == w_rq_head_addr);
    end

    // A hazarded read waits; queued writes go first, and with none queued the
    // read simply stalls until the line in collection reaches the queue.
    assign w_war_hit = |w_war_vec;
    assign w_raw     = ~w_rq_empty & ((|w_raw_vec) |
                       ((r_state == COLLECT) && (r_col_addr == w_rq_head_addr)));
    assign w_load    = ~r_out_valid | o_cmd_ready;
    assign w_sel_w   = ~w_wq_empty & (r_drain | w_raw | w_rq_empty);
    assign w_sel_r   = ~w_rq_empty & ~w_raw & ~w_sel_w;
    assign w_rq_pop  = w_load & w_sel_r;
    assign w_wq_pop  = w_load & w_sel_w;

    assign w_wq_count_next = o_wq_count + WQ_CW'(w_wq_push) - WQ_CW'(w_wq_pop);

    // Drain hysteresis tracks the write-queue occupancy after this edge.
    always_ff @(posedge clk) begin
        if (!rst_n)                                r_drain <= 1'b0;
        else if (w_wq_count_next >= WQ_CW'(WQ_HI)) r_drain <= 1'b1;
        else if (w_wq_count_next <= WQ_CW'(WQ_LO)) r_drain <= 1'b0;
    end

    // Output register: reload whenever empty or being accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_op    <= 1'b0;
            r_out_addr  <= '0;
            r_out_id    <= '0;
            r_out_line  <= '0;
        end else if (w_load) begin
            r_out_valid <= w_sel_w | w_sel_r;
            if (w_sel_w) begin
                r_out_op   <= OP_WRITE;
                r_out_addr <= w_wq_head[WQ_W-1 -: ADDR_W];
                r_out_id   <= w_wq_head[LINE_W +: ID_W];
                r_out_line <= w_wq_head[LINE_W-1:0];
            end else if (w_sel_r) begin
                r_out_op   <= OP_READ;
                r_out_addr <= w_rq_head_addr;
                r_out_id   <= w_rq_head[ID_W-1:0];
                r_out_line <= '0;
            end else begin
                r_out_op   <= 1'b0;
                r_out_addr <= '0;
                r_out_id   <= '0;
                r_out_line <= '0;
            end
        end
    end

    assign o_cmd_valid = r_out_valid;
    assign o_cmd_op    = r_out_op;
    assign o_cmd_addr  = r_out_addr;
    assign o_cmd_id    = r_out_id;
    assign o_cmd_wline = r_out_line;
    assign o_drain     = r_drain;
    assign o_burst_err = r_burst_err;

endmodule
`default_nettype wire

// File: tb/tb_frontend_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frontend_cmd_scheduler
// Purpose  : Directed and random stimulus for frontend_cmd_scheduler, checked
//            cycle by cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frontend_cmd_scheduler;
    import frontend_sched_pkg::*;

    localparam int RQ_DEPTH = 8;
    localparam int WQ_DEPTH = 8;
    localparam int WQ_HI    = 6;
    localparam int WQ_LO    = 2;
    localparam int BLEN     = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_cmd_valid, i_cmd_ready, i_cmd_op;
    logic [31:0]  i_cmd_addr;
    logic [3:0]   i_cmd_id;
    logic         i_wdata_valid, i_wdata_ready, i_wlast;
    logic [63:0]  i_wdata;
    logic         o_cmd_valid, o_cmd_ready, o_cmd_op;
    logic [31:0]  o_cmd_addr;
    logic [3:0]   o_cmd_id;
    logic [255:0] o_cmd_wline;
    logic [3:0]   o_rq_count, o_wq_count;
    logic         o_drain, o_burst_err;

    frontend_cmd_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_addr(i_cmd_addr), .i_cmd_id(i_cmd_id),
        .i_wdata_valid(i_wdata_valid), .i_wdata_ready(i_wdata_ready),
        .i_wdata(i_wdata), .i_wlast(i_wlast),
        .o_cmd_valid(o_cmd_valid), .o_cmd_ready(o_cmd_ready), .o_cmd_op(o_cmd_op),
        .o_cmd_addr(o_cmd_addr), .o_cmd_id(o_cmd_id), .o_cmd_wline(o_cmd_wline),
        .o_rq_count(o_rq_count), .o_wq_count(o_wq_count),
        .o_drain(o_drain), .o_burst_err(o_burst_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    rq_entry_t    m_rq[$];
    wq_entry_t    m_wq[$];
    bit           m_col, m_drain, m_err, m_ready_en, m_out_v, m_out_op, m_fire;
    logic [31:0]  m_col_addr, m_out_addr;
    logic [3:0]   m_col_id, m_out_id;
    logic [255:0] m_col_line, m_out_line;
    int           m_beats;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rq.delete(); m_wq.delete();
        m_col = 0; m_drain = 0; m_err = 0; m_ready_en = 0; m_out_v = 0;
        m_out_op = 0; m_out_addr = '0; m_out_id = '0; m_out_line = '0;
        m_col_addr = '0; m_col_id = '0; m_col_line = '0; m_beats = 0; m_fire = 0;
    endtask

    // Read at queue head targets an address with an older pending write.
    function automatic bit m_hazard();
        if (m_rq.size() == 0) return 1'b0;
        foreach (m_wq[k]) if (m_wq[k].addr == m_rq[0].addr) return 1'b1;
        return m_col && (m_col_addr == m_rq[0].addr);
    endfunction

    function automatic bit m_cmd_ready();
        if (!m_ready_en || m_col) return 1'b0;
        if (i_cmd_op == 1'b0) return m_rq.size() < RQ_DEPTH;
        foreach (m_rq[k]) if (m_rq[k].addr == i_cmd_addr) return 1'b0;
        return m_wq.size() < WQ_DEPTH;
    endfunction

    task automatic model_step(input bit rdy);
        bit haz, take_w, take_r;
        rq_entry_t r;
        wq_entry_t w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        haz    = m_hazard();
        take_w = (m_wq.size() > 0) && (m_drain || haz || m_rq.size() == 0);
        take_r = (m_rq.size() > 0) && !haz && !take_w;
        if (!m_out_v || o_cmd_ready) begin
            m_out_v = take_w || take_r;
            if (take_w) begin
                w = m_wq.pop_front();
                m_out_op = 1; m_out_addr = w.addr; m_out_id = w.id; m_out_line = w.line;
            end else if (take_r) begin
                r = m_rq.pop_front();
                m_out_op = 0; m_out_addr = r.addr; m_out_id = r.id; m_out_line = '0;
            end
        end
        if (i_wdata_valid && m_col) begin
            if (m_beats < BLEN) begin
                m_col_line[m_beats*64 +: 64] = i_wdata;
                m_beats++;
            end else m_err = 1;
            if (i_wlast) begin
                w.addr = m_col_addr; w.id = m_col_id; w.line = m_col_line;
                m_wq.push_back(w);
                m_col = 0;
            end
        end
        m_fire = i_cmd_valid && rdy;
        if (m_fire) begin
            if (i_cmd_op == 1'b0) begin
                r.addr = i_cmd_addr; r.id = i_cmd_id;
                m_rq.push_back(r);
            end else begin
                m_col = 1; m_col_addr = i_cmd_addr; m_col_id = i_cmd_id;
                m_col_line = '0; m_beats = 0;
            end
        end
        if (m_wq.size() >= WQ_HI)      m_drain = 1;
        else if (m_wq.size() <= WQ_LO) m_drain = 0;
        m_ready_en = 1;
    endtask

    task automatic check_regs();
        chk("out_valid", o_cmd_valid, m_out_v);
        if (m_out_v) begin
            chk("out_op", o_cmd_op, m_out_op);
            chk("out_addr", o_cmd_addr, m_out_addr);
            chk("out_id", o_cmd_id, m_out_id);
            chk("out_wline", o_cmd_wline, m_out_line);
        end
        chk("rq_count", o_rq_count, m_rq.size());
        chk("wq_count", o_wq_count, m_wq.size());
        chk("drain", o_drain, m_drain);
        chk("burst_err", o_burst_err, m_err);
    endtask

    // One clock: compare handshake readies mid-cycle, advance the model
    // across the edge, then compare registered outputs.
    task automatic tick();
        bit rdy;
        @(negedge clk);
        rdy = m_cmd_ready();
        chk("cmd_ready", i_cmd_ready, rdy);
        chk("wdata_ready", i_wdata_ready, m_col);
        @(posedge clk);
        #1;
        model_step(rdy);
        check_regs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic send_cmd(input bit op, input logic [31:0] addr, input logic [3:0] id,
                            output bit fired);
        i_cmd_valid = 1; i_cmd_op = op; i_cmd_addr = addr; i_cmd_id = id;
        fired = 0;
        for (int t = 0; t < 100 && !fired; t++) begin
            tick();
            fired = m_fire;
        end
        i_cmd_valid = 0;
        chk("cmd_accept_timeout", fired, 1'b1);
    endtask

    task automatic send_beats(input int n, input logic [63:0] step);
        for (int b = 0; b < n; b++) begin
            i_wdata_valid = 1; i_wdata = step * 64'(b + 1); i_wlast = (b == n - 1);
            tick();
        end
        i_wdata_valid = 0; i_wlast = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        rst_n = 0; i_cmd_valid = 0; i_cmd_op = 0; i_cmd_addr = '0; i_cmd_id = '0;
        i_wdata_valid = 0; i_wdata = '0; i_wlast = 0; o_cmd_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_regs();
        chk("reset_cmd_ready", i_cmd_ready, 1'b0);
        chk("reset_wline", o_cmd_wline, 256'd0);
        rst_n = 1;

        // Single read: visible on the output two edges after acceptance.
        o_cmd_ready = 1;
        send_cmd(1'b0, 32'h100, 4'd1, f);
        tick();
        chk("t1_valid", o_cmd_valid, 1'b1);
        chk("t1_addr", o_cmd_addr, 32'h100);
        chk("t1_wline", o_cmd_wline, 256'd0);
        run(2);

        // Write then read to the same address: write must come out first.
        send_cmd(1'b1, 32'h200, 4'd2, f);
        send_beats(4, 64'd11);
        tick();
        chk("t2_wr_op", o_cmd_op, 1'b1);
        chk("t2_wline", o_cmd_wline, {64'd44, 64'd33, 64'd22, 64'd11});
        send_cmd(1'b0, 32'h200, 4'd3, f);
        run(3);

        // Fill the write queue with the backend stalled to trigger drain.
        o_cmd_ready = 0;
        for (int k = 0; k < 7; k++) begin
            send_cmd(1'b1, 32'h1000 + 32'(k * 64), 4'(k), f);
            send_beats(2, 64'h10);
        end
        send_cmd(1'b0, 32'h2000, 4'd8, f);
        send_cmd(1'b0, 32'h2040, 4'd9, f);
        tick();
        chk("t3_drain", o_drain, 1'b1);
        chk("t3_wq_count", o_wq_count, 4'd6);
        o_cmd_ready = 1;
        run(20);

        // Overlong burst: beats past the line are dropped and flagged.
        send_cmd(1'b1, 32'h3000, 4'd4, f);
        send_beats(6, 64'd1);
        tick();
        chk("t4_burst_err", o_burst_err, 1'b1);
        chk("t4_wline", o_cmd_wline, {64'd4, 64'd3, 64'd2, 64'd1});
        send_cmd(1'b0, 32'h3100, 4'd5, f);
        chk("t4_next_accept", f, 1'b1);
        run(3);

        // WAR guard: a write waits while a same-address read is queued.
        o_cmd_ready = 0;
        send_cmd(1'b0, 32'h2f0, 4'd6, f);
        send_cmd(1'b0, 32'h300, 4'd7, f);
        i_cmd_valid = 1; i_cmd_op = 1; i_cmd_addr = 32'h300; i_cmd_id = 4'd8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_war_block", i_cmd_ready, 1'b0);
        end
        o_cmd_ready = 1;
        send_cmd(1'b1, 32'h300, 4'd8, f);
        send_beats(2, 64'h55);
        run(5);

        // Reset during collection with reads pending discards everything.
        o_cmd_ready = 0;
        send_cmd(1'b0, 32'h400, 4'd1, f);
        send_cmd(1'b0, 32'h440, 4'd2, f);
        send_cmd(1'b0, 32'h480, 4'd3, f);
        send_cmd(1'b1, 32'h500, 4'd4, f);
        i_wdata_valid = 1; i_wlast = 0; i_wdata = 64'hab;
        run(2);
        rst_n = 0; i_wdata_valid = 0;
        tick();
        chk("t6_rq_count", o_rq_count, 4'd0);
        chk("t6_out_valid", o_cmd_valid, 1'b0);
        rst_n = 1; o_cmd_ready = 1;
        i_wdata_valid = 1; i_wlast = 1;
        run(10);
        chk("t6_wq_after", o_wq_count, 4'd0);
        chk("t6_no_write", o_cmd_valid, 1'b0);
        i_wdata_valid = 0; i_wlast = 0;

        // Random traffic over a small address set to provoke hazards.
        for (int c = 0; c < 800; c++) begin
            i_cmd_valid   = ($urandom_range(0, 2) != 0);
            i_cmd_op      = 1'($urandom_range(0, 1));
            i_cmd_addr    = 32'h100 + 32'($urandom_range(0, 5)) * 32'h40;
            i_cmd_id      = 4'($urandom);
            i_wdata_valid = ($urandom_range(0, 3) != 0);
            i_wdata       = {$urandom, $urandom};
            i_wlast       = ($urandom_range(0, 3) == 0);
            o_cmd_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_cmd_valid = 0; i_wdata_valid = 0; i_wlast = 0; o_cmd_ready = 1;
        run(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
